// File: rtl/mult_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  // Iteration count; one result bit is produced per CALC cycle.
  localparam int CYCLES = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Signed variants have OP[0] clear.
  function automatic logic is_signed_op(input logic [1:0] op);
    return !op[0];
  endfunction

  // Divide variants have OP[1] set.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the unsigned datapath: radix-2 shift-add for multiply,
// restoring shift-subtract for divide, over a shared 2*WIDTH accumulator.
//   multiply: acc = {partial product high, remaining multiplier bits}
//   divide:   acc = {partial remainder, dividend bits / quotient bits}
module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;

  // Next accumulator for the selected mode.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, operand};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (rem_shift >= {1'b0, operand}) begin
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes at START, iterated unsigned in CALC and
// sign-corrected in FIX; results land in HI/LO with a one-cycle DONE pulse.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WE_HI,
  input  logic             WE_LO,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(CYCLES);

  state_e             state;
  state_e             state_next;
  logic               div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;
  logic               start_op;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_q),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  assign start_op  = (state == S_IDLE) && START;
  assign last_iter = (cnt == CNT_W'(CYCLES - 1));

  // Operand magnitudes for the signed ops; unsigned ops pass through.
  always_comb begin
    op_signed = is_signed_op(OP);
    op_div    = is_div_op(OP);
    a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;
  end

  // Sign correction of the unsigned result, selected by mode.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      hi_fix = rem_fix;
      lo_fix = b_zero ? '1 : quot_fix;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> CALC -> FIX -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (START) state_next = S_CALC;
      S_CALC:  if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    BUSY = (state != S_IDLE);
  end

  // Working registers: operand capture at START, one iteration per CALC cycle.
  always_ff @(posedge CLK) begin
    // NOTE: these are only read after START loads them, so they carry no reset.
    if (start_op) begin
      div_q   <= op_div;
      neg_res <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_rem <= op_signed && A[WIDTH-1];
      b_zero  <= (B == '0);
      operand <= op_div ? b_mag : a_mag;
      acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
      cnt     <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Architectural HI/LO plus the completion flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      HI       <= '0;
      LO       <= '0;
      DONE     <= 1'b0;
      DIV_ZERO <= 1'b0;
    end else begin
      DONE     <= (state == S_FIX);
      DIV_ZERO <= (state == S_FIX) && div_q && b_zero;
      if (state == S_FIX) begin
        HI <= hi_fix;
        LO <= lo_fix;
      end else if (state == S_IDLE && !START) begin
        if (WE_HI) HI <= A;
        if (WE_LO) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: latency, signed/unsigned results, divide
// corner cases, busy/priority handling and mid-operation reset.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        WE_HI;
  logic        WE_LO;
  logic        BUSY;
  logic        DONE;
  logic        DIV_ZERO;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mult_div dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .OP       (OP),
    .A        (A),
    .B        (B),
    .WE_HI    (WE_HI),
    .WE_LO    (WE_LO),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DIV_ZERO (DIV_ZERO),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called 1 unit after an edge; START sampled at the next edge (k).
  // Returns in cycle k+1 with operands scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    OP = op; A = a; B = b; START = 1'b1;
    step();
    START = 1'b0; OP = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  // Starting in cycle k+1, count BUSY cycles until DONE; n is the cycle index.
  task automatic wait_done(output int busy_cycles, output int done_cycle, output logic dz);
    busy_cycles = 0; done_cycle = -1; dz = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (BUSY) busy_cycles++;
      if (DONE) begin
        done_cycle = n; dz = DIV_ZERO;
        break;
      end
      step();
    end
  endtask

  // Full operation: issue, wait, compare result and flags.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int bc, dc;
    logic dz;
    issue(op, a, b);
    wait_done(bc, dc, dz);
    check({tag, "_done_cycle"}, 64'(dc), 64'd34);
    check({tag, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
    check({tag, "_div_zero"}, 64'(dz), 64'(exp_dz));
  endtask

  initial begin
    int bc, dc, pulses;
    logic dz;
    RST = 1'b1; START = 1'b0; OP = 2'b00; A = '0; B = '0; WE_HI = 1'b0; WE_LO = 1'b0;
    step(); step();
    RST = 1'b0;
    check("reset_state", {59'd0, BUSY, DONE, DIV_ZERO, 2'b00}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    // 1. MULTU max*max with exact latency.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, dc, dz);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_done_cycle", 64'(dc), 64'd34);
    check("multu_busy_in_done", 64'(BUSY), 64'd0);
    check("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    step();
    check("multu_done_pulse", 64'(DONE), 64'd0);

    // 2. MULT -3*5, then DIVU issued in the DONE cycle.
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // 3. Signed divide truncation and overflow wrap.
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    // 4. Divide by zero, unsigned and signed.
    run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    step();
    check("divu_zero_flag_drop", 64'(DIV_ZERO), 64'd0);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    step();

    // 5a. START and WE_HI during CALC are ignored.
    issue(OP_MULTU, 32'd6, 32'd7);
    START = 1'b1; WE_HI = 1'b1; OP = OP_DIVU; A = 32'hDEAD_BEEF; B = 32'd3;
    for (int i = 0; i < 5; i++) step();
    START = 1'b0; WE_HI = 1'b0;
    wait_done(bc, dc, dz);
    check("busy_ignore_done", 64'(dc > 0), 64'd1);
    check("busy_ignore_hilo", {HI, LO}, 64'd42);
    step();

    // 5b. START wins over WE_LO in IDLE.
    WE_LO = 1'b1;
    issue(OP_MULTU, 32'd3, 32'd5);
    WE_LO = 1'b0;
    check("start_over_we_lo", 64'(LO), 64'd42);
    check("start_over_we_busy", 64'(BUSY), 64'd1);
    wait_done(bc, dc, dz);
    check("start_over_we_result", {HI, LO}, 64'd15);
    step();

    // 5c. Simultaneous MTHI/MTLO.
    WE_HI = 1'b1; WE_LO = 1'b1; A = 32'hCAFE_F00D;
    step();
    WE_HI = 1'b0; WE_LO = 1'b0; A = 32'h0;
    check("mthi_mtlo", {HI, LO}, 64'hCAFE_F00D_CAFE_F00D);
    check("mthi_mtlo_no_done", 64'(DONE), 64'd0);

    // 6. Reset mid-MULT aborts with no DONE.
    issue(OP_MULT, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) pulses++;
      step();
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op("after_abort", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'h0000_000C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
